// File: rtl/crc_frame_ctrl.sv
// ---------------------------------------------------------------------------
// crc_frame_ctrl
//
// Byte-serial CRC framer/checker. Each accepted byte is shifted MSB first
// through a WIDTH-bit CRC register (one bit per clock), then forwarded
// downstream. In generate mode (mode = 0) the final CRC bytes are appended,
// MSB byte first, after the last data byte. In check mode (mode = 1) the
// frame is expected to already carry its CRC, and the register is compared
// against RESIDUE when the last byte leaves.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input byte offered
//   in_data    input byte (bit 7 shifted first)
//   in_last    input byte is the last of the frame
//   in_ready   byte accepted on in_valid & in_ready (only while idle)
//   mode       0 = generate/append, 1 = check; sampled with the first byte
//   abort      drop the current frame, return to idle
//   out_valid  out_data/out_last valid
//   out_data   forwarded data byte or CRC byte
//   out_last   final output byte of the frame
//   out_ready  sink accepts on out_valid & out_ready
//   crc_done   one-cycle pulse at frame completion
//   crc_ok     frame result, held until the next crc_done
//   busy       high unless idle between frames
// ---------------------------------------------------------------------------
module crc_frame_ctrl #(
  parameter int                WIDTH   = 16,
  parameter logic [WIDTH-1:0]  POLY    = 16'h1021,
  parameter logic [WIDTH-1:0]  INIT    = 16'hffff,
  parameter logic [WIDTH-1:0]  RESIDUE = '0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  input  logic       mode,
  input  logic       abort,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  input  logic       out_ready,
  output logic       crc_done,
  output logic       crc_ok,
  output logic       busy
);

  localparam int         NBYTES   = WIDTH / 8;
  localparam logic [1:0] IDX_LAST = 2'(NBYTES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_EMIT   = 2'd2;
  localparam logic [1:0] S_APPEND = 2'd3;

  // One serial CRC step, normal (non-reflected) polynomial form.
  function automatic logic [WIDTH-1:0] crc_step(input logic [WIDTH-1:0] c,
                                                input logic             b);
    logic fb;
    fb = c[WIDTH-1] ^ b;
    return (c << 1) ^ (fb ? POLY : '0);
  endfunction

  // Byte idx of the CRC register, idx 0 being the most significant byte.
  function automatic logic [7:0] crc_byte(input logic [WIDTH-1:0] c,
                                          input logic [1:0]       idx);
    logic [WIDTH-1:0] sh;
    sh = c >> (8 * (NBYTES - 1 - int'(idx)));
    return sh[7:0];
  endfunction

  logic [1:0]       state_q, state_d;
  logic             sof_q, sof_d;
  logic [WIDTH-1:0] crc_q, crc_d;
  logic             mode_q, mode_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             done_q, done_d;
  logic             ok_q, ok_d;
  logic             rdy_en_q;
  logic [7:0]       data_q;
  logic             last_q;
  logic             accept;

  // in_ready stays low through reset and rises at the first clock edge after.
  assign in_ready  = rdy_en_q & (state_q == S_IDLE);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == S_EMIT) | (state_q == S_APPEND);
  assign crc_done  = done_q;
  assign crc_ok    = ok_q;
  assign busy      = ~((state_q == S_IDLE) & sof_q);

  always_comb begin
    out_data = '0;
    out_last = 1'b0;
    case (state_q)
      S_EMIT: begin
        out_data = data_q;
        // In generate mode the CRC bytes follow, so the data byte is not last.
        out_last = last_q & mode_q;
      end
      S_APPEND: begin
        out_data = crc_byte(crc_q, idx_q);
        out_last = (idx_q == IDX_LAST);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    sof_d   = sof_q;
    crc_d   = crc_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    ok_d    = ok_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          if (sof_q) begin
            crc_d  = INIT;
            mode_d = mode;
            sof_d  = 1'b0;
          end
        end
      end
      S_SHIFT: begin
        crc_d = crc_step(crc_q, data_q[3'd7 - cnt_q]);
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = S_EMIT;
      end
      S_EMIT: begin
        if (out_ready) begin
          if (!last_q) begin
            state_d = S_IDLE;
          end else if (mode_q) begin
            done_d  = 1'b1;
            ok_d    = (crc_q == RESIDUE);
            sof_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d   = '0;
            state_d = S_APPEND;
          end
        end
      end
      S_APPEND: begin
        if (out_ready) begin
          if (idx_q == IDX_LAST) begin
            done_d  = 1'b1;
            ok_d    = 1'b1;
            sof_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Abort wins over any handshake in the same cycle.
    if (abort) begin
      state_d = S_IDLE;
      sof_d   = 1'b1;
      done_d  = 1'b0;
      ok_d    = ok_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sof_q    <= 1'b1;
      crc_q    <= INIT;
      mode_q   <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= '0;
      done_q   <= 1'b0;
      ok_q     <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sof_q    <= sof_d;
      crc_q    <= crc_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
      ok_q     <= ok_d;
      rdy_en_q <= 1'b1;
    end
  end

  // Byte holding register; only observed in SHIFT/EMIT, so no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      data_q <= in_data;
      last_q <= in_last;
    end
  end

endmodule

// File: tb/tb_crc_frame_ctrl.sv
module tb_crc_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       mode = 1'b0;
  logic       abort = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready, out_valid, out_last, crc_done, crc_ok, busy;
  logic [7:0] out_data;

  crc_frame_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .mode(mode), .abort(abort),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .crc_done(crc_done), .crc_ok(crc_ok), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  logic [8:0] oq[$];
  int         done_cnt = 0;
  logic       done_ok = 1'b0;
  int         accept_cyc = -1;
  int         rise_cyc = -1;
  logic       ov_prev = 1'b0;

  always @(negedge clk) begin
    if (out_valid && out_ready) oq.push_back({out_last, out_data});
    if (out_valid && !ov_prev && rise_cyc < 0) rise_cyc = cyc;
    ov_prev = out_valid;
    if (crc_done) begin
      done_cnt = done_cnt + 1;
      done_ok  = crc_ok;
    end
  end

  task automatic clear_mon();
    oq.delete();
    done_cnt   = 0;
    accept_cyc = -1;
    rise_cyc   = -1;
  endtask

  // All drivers act #1 after a rising edge.
  task automatic send_byte(input logic [7:0] b, input logic last, input logic m, input logic first);
    int t = 0;
    in_valid = 1'b1; in_data = b; in_last = last; mode = m;
    while (!in_ready && t < 300) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 300) chk("accept_timeout", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    if (first) accept_cyc = cyc;
    in_valid = 1'b0;
    mode = ~m;
  endtask

  typedef struct {
    logic       m;
    int         nin;
    logic [7:0] din[11];
    int         nout;
    logic [7:0] dout[11];
    logic       ok;
  } vec_t;

  vec_t vt[5];
  logic [7:0] msg[11];

  // Non-first bytes are offered with the opposite mode value on purpose.
  task automatic send_vec(input int i);
    for (int j = 0; j < vt[i].nin; j++)
      send_byte(vt[i].din[j], j == vt[i].nin - 1, (j == 0) ? vt[i].m : ~vt[i].m, j == 0);
  endtask

  task automatic wait_done();
    int t = 0;
    while (done_cnt == 0 && t < 1000) begin
      @(posedge clk); #1; t++;
    end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic compare_vec(input int i, input string tag);
    chk({tag, "_nout"}, oq.size(), vt[i].nout);
    for (int k = 0; k < vt[i].nout && k < oq.size(); k++) begin
      chk($sformatf("%s_data%0d", tag, k), {24'b0, oq[k][7:0]}, {24'b0, vt[i].dout[k]});
      chk($sformatf("%s_last%0d", tag, k), {31'b0, oq[k][8]}, {31'b0, k == vt[i].nout - 1});
    end
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_crc_ok"}, {31'b0, done_ok}, {31'b0, vt[i].ok});
    chk({tag, "_latency"}, rise_cyc - accept_cyc, 8);
    chk({tag, "_ok_hold"}, {31'b0, crc_ok}, {31'b0, vt[i].ok});
  endtask

  logic [7:0] d0;
  logic       l0;

  initial begin
    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h29, 8'hB1};
    for (int i = 0; i < 5; i++) begin
      vt[i].din = msg; vt[i].dout = msg; vt[i].ok = 1'b1;
    end
    vt[0].m = 1'b0; vt[0].nin = 9;  vt[0].nout = 11;
    vt[1].m = 1'b0; vt[1].nin = 1;  vt[1].nout = 3;
    vt[1].din[0] = 8'h00; vt[1].dout[0] = 8'h00; vt[1].dout[1] = 8'hE1; vt[1].dout[2] = 8'hF0;
    vt[2].m = 1'b1; vt[2].nin = 11; vt[2].nout = 11;
    vt[3].m = 1'b1; vt[3].nin = 11; vt[3].nout = 11; vt[3].ok = 1'b0;
    vt[3].din[4] = 8'h36; vt[3].dout[4] = 8'h36;
    vt[4].m = 1'b1; vt[4].nin = 3;  vt[4].nout = 3;
    vt[4].din[0] = 8'h00; vt[4].din[1] = 8'hE1; vt[4].din[2] = 8'hF0;
    vt[4].dout[0] = 8'h00; vt[4].dout[1] = 8'hE1; vt[4].dout[2] = 8'hF0;

    // Reset state.
    #12;
    chk("rst_in_ready", {31'b0, in_ready}, 0);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_out_data", {24'b0, out_data}, 0);
    chk("rst_out_last", {31'b0, out_last}, 0);
    chk("rst_crc_done", {31'b0, crc_done}, 0);
    chk("rst_crc_ok", {31'b0, crc_ok}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", {31'b0, in_ready}, 1);

    // Table-driven frames, out_ready held high.
    for (int i = 0; i < 5; i++) begin
      clear_mon();
      out_ready = 1'b1;
      send_vec(i);
      wait_done();
      compare_vec(i, $sformatf("vec%0d", i));
    end

    // Back-pressure in EMIT of the first byte and on the 2nd CRC byte.
    clear_mon();
    out_ready = 1'b0;
    fork
      send_vec(0);
      begin
        int t = 0;
        while (!out_valid && t < 300) begin @(posedge clk); #1; t++; end
        d0 = out_data; l0 = out_last;
        chk("stall1_byte", {24'b0, d0}, 32'h31);
        repeat (5) begin
          @(posedge clk); #1;
          chk("stall1_valid", {31'b0, out_valid}, 1);
          chk("stall1_data", {24'b0, out_data}, {24'b0, d0});
          chk("stall1_last", {31'b0, out_last}, {31'b0, l0});
        end
        out_ready = 1'b1;
        t = 0;
        while (oq.size() < 10 && t < 1000) begin @(posedge clk); #1; t++; end
        out_ready = 1'b0;
        repeat (5) begin
          @(posedge clk); #1;
          chk("stall2_valid", {31'b0, out_valid}, 1);
          chk("stall2_data", {24'b0, out_data}, 32'hB1);
          chk("stall2_last", {31'b0, out_last}, 1);
        end
        out_ready = 1'b1;
      end
    join
    wait_done();
    compare_vec(0, "stall");

    // Abort during SHIFT of the third byte.
    clear_mon();
    out_ready = 1'b1;
    send_byte(8'h31, 1'b0, 1'b0, 1'b1);
    send_byte(8'h32, 1'b0, 1'b1, 1'b0);
    send_byte(8'h33, 1'b0, 1'b1, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_out_valid", {31'b0, out_valid}, 0);
    chk("abort_in_ready", {31'b0, in_ready}, 1);
    chk("abort_busy", {31'b0, busy}, 0);
    repeat (20) begin @(posedge clk); #1; end
    chk("abort_no_done", done_cnt, 0);
    clear_mon();
    send_vec(0);
    wait_done();
    compare_vec(0, "after_abort");

    // Reset pulse while the second CRC byte is pending.
    clear_mon();
    out_ready = 1'b1;
    fork
      send_vec(0);
      begin
        int t = 0;
        while (oq.size() < 10 && t < 1000) begin @(posedge clk); #1; t++; end
      end
    join
    out_ready = 1'b0;
    chk("pre_rst_appending", {31'b0, out_valid}, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'b0, out_valid}, 0);
    chk("mid_rst_out_data", {24'b0, out_data}, 0);
    chk("mid_rst_out_last", {31'b0, out_last}, 0);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 0);
    chk("mid_rst_crc_ok", {31'b0, crc_ok}, 0);
    chk("mid_rst_busy", {31'b0, busy}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_no_done", done_cnt, 0);
    clear_mon();
    out_ready = 1'b1;
    send_vec(0);
    wait_done();
    compare_vec(0, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/crc_frame_ctrl.md
CRC_FRAME_CTRL -- requirements
Module: crc_frame_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, CRC register width; a multiple of 8 between 8 and 32.
REQ-002 SHALL have parameter POLY, default 16'h1021, generator polynomial in normal (non-reflected) form.
REQ-003 SHALL have parameter INIT, default 16'hffff, register value loaded at frame start.
REQ-004 SHALL have parameter RESIDUE, default 0, expected register value after a good frame plus its CRC in check mode.
REQ-005 Ports, clock and reset first:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  byte offered.
- in_data  in  8  byte; bit 7 is shifted first.
- in_last  in  1  last byte of frame.
- in_ready  out  1  byte accepted when in_valid & in_ready at a rising edge.
- mode  in  1  0 = generate/append, 1 = check; sampled with the first byte of each frame.
- abort  in  1  discard the current frame.
- out_valid  out  1  out_data valid.
- out_data  out  8  forwarded byte or CRC byte.
- out_last  out  1  final output byte of frame.
- out_ready  in  1  sink accepts when out_valid & out_ready at a rising edge.
- crc_done  out  1  one-cycle pulse at frame completion.
- crc_ok  out  1  frame result; valid while crc_done is high.
- busy  out  1  high in any state except IDLE with sof = 1.

Function
REQ-006 SHALL implement states IDLE, SHIFT, EMIT and APPEND, plus an internal sof flag that is 1 when the next accepted byte starts a frame.
REQ-007 in_ready SHALL equal (state == IDLE); a byte is accepted only in IDLE.
REQ-008 On acceptance the block SHALL latch in_data and in_last and go to SHIFT with the bit counter at 0; if sof = 1 it SHALL also load crc = INIT, latch mode and clear sof.
REQ-009 SHIFT SHALL process one bit per cycle, MSB first:
- fb = crc[WIDTH-1] ^ bit;
- crc = (crc << 1) ^ (fb ? POLY : 0), truncated to WIDTH.
REQ-010 After the 8th SHIFT cycle the block SHALL go to EMIT; out_valid SHALL rise exactly 8 cycles after the acceptance edge.
REQ-011 EMIT SHALL drive out_valid = 1, out_data = the latched byte, and out_last = latched_last & mode_latched; these SHALL be held stable until out_ready.
REQ-012 On an EMIT handshake:
- not last: go to IDLE.
- last, check mode: pulse crc_done, set crc_ok = (crc == RESIDUE), set sof = 1, go to IDLE.
- last, generate mode: go to APPEND with byte index 0.
REQ-013 APPEND SHALL emit the WIDTH/8 bytes of crc, MSB byte first, holding each byte until out_ready; out_last SHALL be high on the final byte.
REQ-014 On the final APPEND handshake the block SHALL pulse crc_done with crc_ok = 1, set sof = 1 and go to IDLE.
REQ-015 crc_ok SHALL hold its value until the next crc_done pulse.
REQ-016 mode changes mid-frame SHALL be ignored.
REQ-017 in_valid while not IDLE SHALL be ignored, since in_ready = 0.
REQ-018 When abort is high at a rising edge in any state, the block SHALL go to IDLE with sof = 1, out_valid = 0 and no crc_done pulse; abort SHALL take priority over any simultaneous handshake.
REQ-019 A frame consisting of a single byte with in_last = 1 SHALL be legal.
REQ-020 Back-to-back frames SHALL be supported: a new frame's first byte may be accepted in the cycle immediately after crc_done.

Reset
REQ-021 While rst_n = 0 the block SHALL hold state = IDLE, sof = 1, crc = INIT, and outputs in_ready = 0, out_valid = 0, out_data = 0, out_last = 0, crc_done = 0, crc_ok = 0, busy = 0.
REQ-022 After rst_n rises, in_ready SHALL be 1 from the first clock edge.
REQ-023 Reset asserted mid-frame SHALL discard all partial frame state with no crc_done pulse.

Verification
REQ-024 Bench SHALL cover the following directed scenarios:
- Generate mode, ASCII "123456789", out_ready = 1: output is the 9 bytes then 0x29, 0xB1 (out_last on 0xB1); crc_done with crc_ok = 1; out_valid for the first byte 8 cycles after its acceptance.
- Generate mode, single byte 0x00 with in_last = 1: output 0x00, 0xE1, 0xF0.
- Check mode, "123456789", 0x29, 0xB1: crc_ok = 1 with out_last on 0xB1; repeat with the 5th byte changed to 0x36: crc_ok = 0.
- out_ready held low for 5 cycles during EMIT and during the 2nd APPEND byte: out_data and out_last stable, no bytes lost or duplicated, same CRC.
- abort asserted in SHIFT of the 3rd byte, then the "123456789" frame is sent: no crc_done for the aborted frame; the next frame gives 0x29B1.
- rst_n pulsed low during APPEND: outputs go to the reset values immediately; the next frame is processed from INIT correctly.
